// File: rtl/prom_fetch_if.sv
// Bundle of request, PROM and output-stream signals for the PROM fetch controller.
// The master side issues bursts and models the PROM; the slave side is the controller.
interface prom_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [14:0] req_addr;
  logic [3:0]  req_len;
  logic [14:0] rom_addr;
  logic        rom_cs_n;
  logic        rom_oe_n;
  logic [7:0]  rom_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [7:0]  dout_data;
  logic        dout_last;
  logic        busy;
  logic        err;

  modport slave (
    input  req_valid, req_addr, req_len, rom_data, dout_ready,
    output req_ready, rom_addr, rom_cs_n, rom_oe_n,
           dout_valid, dout_data, dout_last, busy, err
  );

  modport master (
    output req_valid, req_addr, req_len, rom_data, dout_ready,
    input  req_ready, rom_addr, rom_cs_n, rom_oe_n,
           dout_valid, dout_data, dout_last, busy, err
  );
endinterface

// File: rtl/prom_fetch_ctrl.sv
// Burst reader for a 32Kx8 asynchronous PROM: IDLE -> ACCESS (WAIT_CYCLES+1) -> OUT per byte.
// Optional macro PROM_FETCH_ADDR_CHK_EN rejects bursts that would run past 0x7FFF (err pulse).
module prom_fetch_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input logic         clk,
  input logic         rst,
  prom_fetch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, OUT} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_reg, state_next;
  logic [14:0] addr_reg, addr_next;
  logic [3:0]  remaining_reg, remaining_next;
  logic [3:0]  wait_reg, wait_next;
  logic [7:0]  data_reg, data_next;
  logic        addr_bad;

`ifdef PROM_FETCH_ADDR_CHK_EN
  logic [15:0] end_addr;
  logic        err_reg;

  assign end_addr = {1'b0, bus.req_addr} + {12'd0, bus.req_len};
  assign addr_bad = (end_addr > 16'h7FFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_reg <= 1'b0;
    else     err_reg <= (state_reg == IDLE) && bus.req_valid && addr_bad;
  end

  assign bus.err = err_reg;
`else
  assign addr_bad = 1'b0;
  assign bus.err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      wait_reg      <= '0;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      wait_reg      <= wait_next;
      data_reg      <= data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    wait_next      = wait_reg;
    data_next      = data_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid && !addr_bad) begin
          addr_next      = bus.req_addr;
          remaining_next = bus.req_len;
          wait_next      = WAIT_INIT;
          state_next     = ACCESS;
        end
      end
      ACCESS: begin
        // Sample the PROM on the final access edge; address stays put throughout.
        if (wait_reg == 4'd0) begin
          data_next  = bus.rom_data;
          state_next = OUT;
        end else begin
          wait_next = wait_reg - 4'd1;
        end
      end
      OUT: begin
        if (bus.dout_ready) begin
          if (remaining_reg == 4'd0) begin
            state_next = IDLE;
          end else begin
            addr_next      = addr_reg + 15'd1;
            remaining_next = remaining_reg - 4'd1;
            wait_next      = WAIT_INIT;
            state_next     = ACCESS;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.rom_cs_n   = (state_reg != ACCESS);
  assign bus.rom_oe_n   = (state_reg != ACCESS);
  assign bus.rom_addr   = addr_reg;
  assign bus.dout_valid = (state_reg == OUT);
  assign bus.dout_data  = data_reg;
  assign bus.dout_last  = (state_reg == OUT) && (remaining_reg == 4'd0);

endmodule

// File: doc/prom_fetch_ctrl.md
PROM_FETCH_CTRL -- requirements
Module: prom_fetch_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra access cycles before the read data is sampled; legal range 0..15.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  burst request present.
REQ-005 req_ready  out  1  controller can accept a request.
REQ-006 req_addr  in  15  start byte address.
REQ-007 req_len  in  4  burst length minus 1 (0 = 1 byte, 15 = 16 bytes).
REQ-008 rom_addr  out  15  address to the 32Kx8 PROM.
REQ-009 rom_cs_n  out  1  PROM chip select, active low.
REQ-010 rom_oe_n  out  1  PROM output enable, active low.
REQ-011 rom_data  in  8  PROM read data.
REQ-012 dout_valid  out  1  fetched byte present.
REQ-013 dout_ready  in  1  consumer accepts the byte.
REQ-014 dout_data  out  8  fetched byte.
REQ-015 dout_last  out  1  high with the final byte of a burst.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and OUT.
REQ-019 In IDLE, req_ready SHALL be 1; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-020 On acceptance, the controller SHALL latch req_addr into the address register, load remaining=req_len, load wait=WAIT_CYCLES, and enter ACCESS.
REQ-021 In ACCESS, the controller SHALL drive rom_cs_n=0 and rom_oe_n=0 with rom_addr held stable, decrementing wait each cycle; ACCESS SHALL last WAIT_CYCLES+1 cycles.
REQ-022 On the last ACCESS edge, the controller SHALL register rom_data into dout_data and enter OUT; taking the acceptance edge as cycle 0, dout_valid SHALL first be 1 in cycle WAIT_CYCLES+2.
REQ-023 In OUT: dout_valid=1, rom_cs_n=1, rom_oe_n=1, and dout_data and dout_last SHALL be held stable until dout_ready=1.
REQ-024 dout_last SHALL equal 1 in OUT exactly when remaining=0.
REQ-025 On an OUT handshake with remaining=0, the FSM SHALL enter IDLE.
REQ-026 On an OUT handshake with remaining>0, the controller SHALL increment the address, decrement remaining, reload wait, and re-enter ACCESS.
REQ-027 The address increment SHALL be modulo 2^15, so 0x7FFF+1 = 0x0000 (subject to REQ-034).
REQ-028 req_ready SHALL be 0 outside IDLE; req_valid outside IDLE SHALL be ignored and SHALL NOT be latched.
REQ-029 Outside ACCESS, rom_cs_n and rom_oe_n SHALL both be 1.
REQ-030 dout_valid SHALL NOT depend combinationally on dout_ready.

Reset
REQ-031 Asserting rst SHALL immediately force IDLE, regardless of state, including mid-burst; the in-flight byte is discarded.
REQ-032 Reset values: rom_cs_n=1, rom_oe_n=1, rom_addr=0, dout_valid=0, dout_data=0, dout_last=0, busy=0, err=0, req_ready=1 (combinational from IDLE).
REQ-033 After rst deasserts, the first request SHALL be accepted on the next edge where req_valid=1.

Configuration
REQ-034 With macro PROM_FETCH_ADDR_CHK_EN defined, a request where req_addr+req_len > 0x7FFF SHALL NOT be accepted into ACCESS: the FSM stays in IDLE, err pulses for one cycle, and no PROM access occurs.
REQ-035 Without PROM_FETCH_ADDR_CHK_EN, every request SHALL be accepted, the address SHALL wrap per REQ-027, and err SHALL be constant 0.

Verification
REQ-036 Single read: WAIT_CYCLES=1, addr=0x0010, len=0, PROM[0x10]=0xA5, dout_ready=1 -> dout_valid in cycle 3, dout_data=0xA5, dout_last=1, then IDLE.
REQ-037 Burst with backpressure: addr=0x0100, len=3, dout_ready low for 5 cycles on the 2nd byte -> 4 bytes PROM[0x100..0x103] in order; the held byte is stable; dout_last only on the 4th byte.
REQ-038 Wrap/check: addr=0x7FFE, len=3 -> with the macro, err=1 for 1 cycle and rom_cs_n stays 1; without it, bytes come from 0x7FFE, 0x7FFF, 0x0000, 0x0001.
REQ-039 Reset mid-burst: rst asserted during ACCESS of the 2nd byte of a len=7 burst -> same cycle rom_cs_n=1, dout_valid=0, busy=0; a new request after release fetches correctly.
REQ-040 Request ignored while busy: req_valid pulsed during OUT with addr=0x0200 -> no second burst starts; req_ready=0 until IDLE.
REQ-041 WAIT_CYCLES=4 sweep: each byte shows exactly 5 cycles with rom_cs_n=0 and rom_oe_n=0, followed by OUT with both high.
